// File: rtl/dmem_dump_ctrl.sv
// Data-memory port arbiter: core pass-through plus a
// sequential memory dump engine with valid/ready output.
module dmem_dump_ctrl #(
  parameter int N      = 64,
  parameter int ADDR_W = 5
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [N-1:0]      cpu_addr,
  input  logic              cpu_we,
  input  logic [N-1:0]      cpu_wdata,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [N-1:0]      mem_wdata,
  input  logic [N-1:0]      mem_rdata,
  input  logic              dump,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [N-1:0]      dump_data,
  output logic [ADDR_W-1:0] dump_index,
  output logic              dump_busy,
  output logic              dump_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CAPT,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_idx;
  logic                r_dump_q;
  logic [N-1:0]        r_data;
  logic [ADDR_W-1:0]   r_index;
  logic                w_start;
  logic                w_accept;
  logic                w_unused;

  // Only the word-address field of the byte address is used.
  assign w_unused = ^{cpu_addr[N-1:ADDR_W+3],
                      cpu_addr[2:0]};

  assign w_start  = (r_state == S_IDLE) &&
                    dump && !r_dump_q;
  assign w_accept = (r_state == S_SEND) &&
                    dump_ready;

  assign dump_data  = r_data;
  assign dump_index = r_index;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_dump_q <= 1'b0;
      r_data   <= '0;
      r_index  <= '0;
    end else begin
      r_state  <= w_next;
      r_dump_q <= dump;
      if (w_start) begin
        r_idx <= '0;
      end else if (w_accept && r_idx != LAST) begin
        r_idx <= r_idx + 1'b1;
      end
      if (r_state == S_CAPT) begin
        r_data  <= mem_rdata;
        r_index <= r_idx;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    cpu_stall  = 1'b1;
    mem_addr   = r_idx;
    mem_we     = 1'b0;
    mem_wdata  = cpu_wdata;
    dump_valid = 1'b0;
    dump_busy  = 1'b1;
    dump_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        cpu_stall = 1'b0;
        dump_busy = 1'b0;
        mem_addr  = cpu_addr[ADDR_W+2:3];
        mem_we    = cpu_we;
        if (w_start) begin
          w_next = S_ADDR;
        end
      end
      S_ADDR: begin
        w_next = S_CAPT;
      end
      S_CAPT: begin
        w_next = S_SEND;
      end
      S_SEND: begin
        dump_valid = 1'b1;
        if (dump_ready) begin
          w_next = (r_idx == LAST) ? S_DONE
                                   : S_ADDR;
        end
      end
      S_DONE: begin
        dump_done = 1'b1;
        w_next    = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// Bench for dmem_dump_ctrl: pass-through vector table
// plus hand-written dump, backpressure and reset sequences.
module tb_dmem_dump_ctrl;

  localparam int N      = 64;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      cpu_addr;
  logic              cpu_we;
  logic [N-1:0]      cpu_wdata;
  logic              cpu_stall;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [N-1:0]      mem_wdata;
  logic [N-1:0]      mem_rdata;
  logic              dump;
  logic              dump_valid;
  logic              dump_ready;
  logic [N-1:0]      dump_data;
  logic [ADDR_W-1:0] dump_index;
  logic              dump_busy;
  logic              dump_done;

  logic [N-1:0] mem [DEPTH];
  logic [N-1:0] exp_mem [DEPTH];
  logic         preload;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_dump_ctrl #(.N(N), .ADDR_W(ADDR_W)) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_we     (cpu_we),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .dump       (dump),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_data  (dump_data),
    .dump_index (dump_index),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done)
  );

  // Synchronous-read memory, read-before-write.
  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < DEPTH; k++)
        mem[k] <= 64'(k) * 64'h11;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic [4:0]  e_addr;
    logic        e_we;
  } pt_vec_t;

  pt_vec_t vecs [6];

  // Runs one dump from the edge cycle to one cycle past DONE.
  task automatic run_dump(input bit bp,
                          input bit tog,
                          input bit es);
    int cyc = 0;
    int n = 0;
    int ndone = 0;
    int done_cyc = -1;
    int hold = 0;
    bit ok = 1'b1;
    @(negedge clk);
    dump       = 1'b1;
    dump_ready = 1'b1;
    cpu_we     = es;
    cpu_addr   = es ? 64'h08 : 64'h0;
    cpu_wdata  = 64'h55;
    #1;
    chk("edge_stall", cpu_stall, 0);
    chk("edge_busy", dump_busy, 0);
    if (es) begin
      chk("edge_we", mem_we, 1);
      chk("edge_addr", mem_addr, 1);
    end
    while (ndone == 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      cpu_we = 1'b1;
      cpu_addr = 64'h10;
      if (tog && (cyc == 40 || cyc == 60))
        dump = 1'b0;
      if (tog && (cyc == 41 || cyc == 61))
        dump = 1'b1;
      dump_ready = !(bp && n == 4 && hold < 10);
      #1;
      if (!cpu_stall || !dump_busy || mem_we)
        ok = 1'b0;
      if (dump_valid) begin
        if (n < DEPTH) begin
          chk("dump_index", dump_index, n[4:0]);
          chk("dump_data", dump_data, exp_mem[n]);
        end
        if (dump_ready) n++;
        else hold++;
      end
      if (dump_done) begin
        ndone++;
        done_cyc = cyc;
      end
    end
    chk("words", n, DEPTH);
    chk("done_cycle", done_cyc, bp ? 107 : 97);
    chk("stall_hold", ok, 1);
    if (bp) chk("bp_hold", hold, 10);
    @(negedge clk);
    cpu_we = 1'b0;
    #1;
    chk("post_done", dump_done, 0);
    chk("post_busy", dump_busy, 0);
    chk("post_stall", cpu_stall, 0);
  endtask

  initial begin
    reset      = 1'b1;
    preload    = 1'b0;
    cpu_addr   = '0;
    cpu_we     = 1'b0;
    cpu_wdata  = '0;
    dump       = 1'b0;
    dump_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++)
      exp_mem[k] = 64'(k) * 64'h11;

    vecs[0] = '{64'h18, 1, 64'hDEAD, 5'd3, 1};
    vecs[1] = '{64'h00, 0, 64'h1234, 5'd0, 0};
    vecs[2] = '{64'hFF, 1, 64'h7777, 5'd31, 1};
    vecs[3] = '{64'h100, 1, 64'h0BAD, 5'd0, 1};
    vecs[4] = '{64'h107, 0, 64'h0, 5'd0, 0};
    vecs[5] = '{64'hFFFF_0000_0000_00A8, 1,
                64'hCAFE, 5'd21, 1};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", cpu_stall, 0);
    chk("rst_busy", dump_busy, 0);
    chk("rst_valid", dump_valid, 0);
    chk("rst_done", dump_done, 0);
    chk("rst_data", dump_data, 0);
    chk("rst_index", dump_index, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cpu_addr  = vecs[i].addr;
      cpu_we    = vecs[i].we;
      cpu_wdata = vecs[i].wdata;
      #1;
      chk("pt_addr", mem_addr, vecs[i].e_addr);
      chk("pt_we", mem_we, vecs[i].e_we);
      chk("pt_wdata", mem_wdata, vecs[i].wdata);
      chk("pt_stall", cpu_stall, 0);
    end

    @(negedge clk);
    cpu_we  = 1'b0;
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;

    run_dump(1'b0, 1'b0, 1'b0);

    begin
      bit again = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        #1;
        if (dump_busy || cpu_stall) again = 1'b1;
      end
      chk("no_retrigger", again, 0);
    end
    @(negedge clk);
    dump = 1'b0;

    run_dump(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    dump = 1'b0;

    exp_mem[1] = 64'h55;
    run_dump(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    dump = 1'b0;

    begin
      int c = 0;
      @(negedge clk);
      dump = 1'b1;
      do begin
        @(negedge clk);
        c++;
        #1;
      end while (!(dump_valid && dump_index == 7)
                 && c < 100);
      chk("reach_idx7", dump_index, 7);
      reset = 1'b1;
      cpu_addr = 64'h28;
      #1;
      chk("rst_mid_valid", dump_valid, 0);
      chk("rst_mid_stall", cpu_stall, 0);
      chk("rst_mid_busy", dump_busy, 0);
      chk("rst_mid_addr", mem_addr, 5);
      @(negedge clk);
      dump  = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      cpu_addr = 64'h30;
      #1;
      chk("after_rst_addr", mem_addr, 6);
      chk("after_rst_busy", dump_busy, 0);
      chk("after_rst_data", dump_data, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
